// File: rtl/leaf_pkg.sv
// Shared packet geometry, credit constants and the packet builder for the BFT leaf output path.
package leaf_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int NUM_OUT_PORTS = 2;
    localparam int CREDIT_BITS   = 8;
    localparam int CREDIT_INIT   = 128;

    localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int DPORT_LSB   = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = DPORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

    typedef logic [PAYLOAD_BITS-1:0]  payload_t;
    typedef logic [NUM_LEAF_BITS-1:0] leaf_t;
    typedef logic [NUM_PORT_BITS-1:0] port_t;
    typedef logic [NUM_ADDR_BITS-1:0] addr_t;
    typedef logic [CREDIT_BITS-1:0]   credit_t;
    typedef logic [PACKET_BITS-1:0]   packet_t;

    function automatic packet_t make_packet(leaf_t leaf, port_t dport, addr_t addr, payload_t payload);
        packet_t pkt;
        pkt                                 = '0;
        pkt[VALID_BIT]                      = 1'b1;
        pkt[LEAF_LSB +: NUM_LEAF_BITS]      = leaf;
        pkt[DPORT_LSB +: NUM_PORT_BITS]     = dport;
        pkt[ADDR_LSB +: NUM_ADDR_BITS]      = addr;
        pkt[PAYLOAD_LSB +: PAYLOAD_BITS]    = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_out_packetizer_if.sv
// User-side, BFT-side, credit-return and destination-config signals of the leaf output packetizer.
interface leaf_out_packetizer_if;
    import leaf_pkg::*;

    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    packet_t                               dout_leaf_interface2bft;
    logic                                  bft_ready;
    logic                                  credit_vld;
    port_t                                 credit_port;
    credit_t                               credit_amt;
    logic                                  cfg_we;
    port_t                                 cfg_port;
    leaf_t                                 cfg_leaf;
    port_t                                 cfg_dport;

    modport slave (
        input  din_leaf_user2interface, vld_user2interface, bft_ready,
        input  credit_vld, credit_port, credit_amt,
        input  cfg_we, cfg_port, cfg_leaf, cfg_dport,
        output ack_interface2user, dout_leaf_interface2bft
    );

    modport master (
        output din_leaf_user2interface, vld_user2interface, bft_ready,
        output credit_vld, credit_port, credit_amt,
        output cfg_we, cfg_port, cfg_leaf, cfg_dport,
        input  ack_interface2user, dout_leaf_interface2bft
    );

endinterface

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer that moves past each winner.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
        grant    = '0;
        winner   = '0;
        found    = 1'b0;
        idx      = 0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && enable && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = IW'(idx);
            end
        end
        if (found) rr_ptr_d = (int'(winner) == N - 1) ? '0 : winner + IW'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
        if (!reset_n) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Leaf output packetizer: arbitrates user ports under credit flow control and wraps words into BFT packets.
module leaf_out_packetizer
    import leaf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    leaf_out_packetizer_if.slave bus
);

    localparam int N   = NUM_OUT_PORTS;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int CW1 = CREDIT_BITS + 1;

    packet_t        held_q, held_d;
    credit_t        credit_q [N];
    credit_t        credit_d [N];
    addr_t          addr_q [N];
    addr_t          addr_d [N];
    leaf_t          leaf_tbl_q [N];
    leaf_t          leaf_tbl_d [N];
    port_t          dport_tbl_q [N];
    port_t          dport_tbl_d [N];

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IW-1:0]  winner;
    logic           slot_free;
    packet_t        new_pkt;
    logic [CW1-1:0] credit_sum;

    assign slot_free = !held_q[VALID_BIT] || bus.bft_ready;

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) req[i] = bus.vld_user2interface[i] && (credit_q[i] != '0);
    end

    // Gating enable with reset_n keeps ack low in a reset cycle even though the arbiter is combinational.
    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .enable  (slot_free && reset_n),
        .grant   (grant),
        .winner  (winner)
    );

    assign bus.ack_interface2user      = grant;
    assign bus.dout_leaf_interface2bft = held_q;

    always_comb begin
        held_d      = held_q;
        credit_d    = credit_q;
        addr_d      = addr_q;
        leaf_tbl_d  = leaf_tbl_q;
        dport_tbl_d = dport_tbl_q;
        credit_sum  = '0;

        // Table entries are read before this cycle's cfg write lands, so a same-cycle grant sees the old route.
        new_pkt = make_packet(leaf_tbl_q[winner], dport_tbl_q[winner], addr_q[winner],
                              bus.din_leaf_user2interface[int'(winner)*PAYLOAD_BITS +: PAYLOAD_BITS]);

        if (|grant)             held_d = new_pkt;
        else if (bus.bft_ready) held_d = '0;

        for (int i = 0; i < N; i++) begin
            addr_d[i]  = addr_q[i] + addr_t'(grant[i]);
            credit_sum = {1'b0, credit_q[i]} - CW1'(grant[i])
                       + ((bus.credit_vld && int'(bus.credit_port) == i) ? {1'b0, bus.credit_amt} : '0);
            credit_d[i] = credit_sum[CREDIT_BITS] ? '1 : credit_sum[CREDIT_BITS-1:0];
            if (bus.cfg_we && int'(bus.cfg_port) == i) begin
                leaf_tbl_d[i]  = bus.cfg_leaf;
                dport_tbl_d[i] = bus.cfg_dport;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_q <= '0;
            // NOTE: these per-port arrays are a handful of flops with defined reset contents, not a RAM.
            for (int i = 0; i < N; i++) begin
                credit_q[i]    <= credit_t'(CREDIT_INIT);
                addr_q[i]      <= '0;
                leaf_tbl_q[i]  <= '0;
                dport_tbl_q[i] <= '0;
            end
        end else begin
            held_q      <= held_d;
            credit_q    <= credit_d;
            addr_q      <= addr_d;
            leaf_tbl_q  <= leaf_tbl_d;
            dport_tbl_q <= dport_tbl_d;
        end
    end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Randomized scoreboard bench for leaf_out_packetizer against a port-level behavioural model.
module tb_leaf_out_packetizer;
    import leaf_pkg::*;

    localparam int N = NUM_OUT_PORTS;
    localparam int CREDIT_MAX = (1 << CREDIT_BITS) - 1;
    localparam int ADDR_MOD   = 1 << NUM_ADDR_BITS;
    localparam logic [PACKET_BITS-1:0] SPEC_PKT = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};

    typedef struct {
        logic                       rst_n;
        logic [N-1:0]               vld;
        logic [N*PAYLOAD_BITS-1:0]  din;
        logic                       rdy;
        logic                       cv;
        port_t                      cp;
        credit_t                    ca;
        logic                       cw;
        port_t                      cfp;
        leaf_t                      cl;
        port_t                      cd;
    } stim_t;

    logic clk;
    logic reset_n;
    leaf_out_packetizer_if bus ();

    leaf_out_packetizer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    bit      mon_en   = 1'b0;
    packet_t exp_q [$];

    int m_credit [N];
    int m_addr   [N];
    int m_leaf   [N];
    int m_dport  [N];
    int m_rr;
    bit m_held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = CREDIT_INIT;
            m_addr[i]   = 0;
            m_leaf[i]   = 0;
            m_dport[i]  = 0;
        end
        m_rr   = 0;
        m_held = 1'b0;
        exp_q.delete();
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.vld = '0; s.din = '0; s.rdy = 1'b0;
        s.cv = 1'b0; s.cp = '0; s.ca = '0;
        s.cw = 1'b0; s.cfp = '0; s.cl = '0; s.cd = '0;
        return s;
    endfunction

    // One clock cycle: drive at the falling edge, check ack once settled, advance the model.
    task automatic step(input stim_t s);
        int          w;
        int          c;
        logic [N-1:0] exp_ack;
        packet_t     pkt;
        @(negedge clk);
        reset_n                     = s.rst_n;
        bus.vld_user2interface      = s.vld;
        bus.din_leaf_user2interface = s.din;
        bus.bft_ready               = s.rdy;
        bus.credit_vld              = s.cv;
        bus.credit_port             = s.cp;
        bus.credit_amt              = s.ca;
        bus.cfg_we                  = s.cw;
        bus.cfg_port                = s.cfp;
        bus.cfg_leaf                = s.cl;
        bus.cfg_dport               = s.cd;
        #1;
        if (!s.rst_n) begin
            check("ack_in_reset", bus.ack_interface2user, '0);
            @(posedge clk);
            #1 model_reset();
            return;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (w < 0 && s.vld[p] && m_credit[p] != 0 && (!m_held || s.rdy)) w = p;
        end
        exp_ack = '0;
        if (w >= 0) exp_ack[w] = 1'b1;
        check("ack", bus.ack_interface2user, exp_ack);
        if (w >= 0) begin
            pkt = {1'b1, NUM_LEAF_BITS'(m_leaf[w]), NUM_PORT_BITS'(m_dport[w]),
                   NUM_ADDR_BITS'(m_addr[w]), s.din[w*PAYLOAD_BITS +: PAYLOAD_BITS]};
            exp_q.push_back(pkt);
        end
        for (int i = 0; i < N; i++) begin
            c = m_credit[i] - ((i == w) ? 1 : 0) + ((s.cv && int'(s.cp) == i) ? int'(s.ca) : 0);
            m_credit[i] = (c > CREDIT_MAX) ? CREDIT_MAX : c;
            if (i == w) m_addr[i] = (m_addr[i] + 1) % ADDR_MOD;
            if (s.cw && int'(s.cfp) == i) begin
                m_leaf[i]  = int'(s.cl);
                m_dport[i] = int'(s.cd);
            end
        end
        m_held = (w >= 0) || (m_held && !s.rdy);
        if (w >= 0) m_rr = (w + 1) % N;
    endtask

    // Monitor: the held packet must match the oldest outstanding expectation; it retires on bft_ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (bus.dout_leaf_interface2bft[PACKET_BITS-1]) begin
                    if (exp_q.size() == 0) check("dout_unexpected", bus.dout_leaf_interface2bft, '0);
                    else begin
                        check("dout_pkt", bus.dout_leaf_interface2bft, exp_q[0]);
                        if (bus.bft_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check("dout_idle", bus.dout_leaf_interface2bft, '0);
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset_n = 1'b0;
        bus.vld_user2interface = '0; bus.din_leaf_user2interface = '0; bus.bft_ready = 1'b0;
        bus.credit_vld = 1'b0; bus.credit_port = '0; bus.credit_amt = '0;
        bus.cfg_we = 1'b0; bus.cfg_port = '0; bus.cfg_leaf = '0; bus.cfg_dport = '0;
        model_reset();

        s = idle(); s.rst_n = 1'b0;
        repeat (3) step(s);
        mon_en = 1'b1;

        s = idle();
        repeat (10) step(s);

        s = idle(); s.cw = 1'b1; s.cfp = 4'd1; s.cl = 5'd3; s.cd = 4'd2;
        step(s);
        s = idle(); s.vld = 2'b10; s.din[2*PAYLOAD_BITS-1:PAYLOAD_BITS] = 32'hDEADBEEF; s.rdy = 1'b1;
        step(s);
        s = idle(); s.rdy = 1'b1;
        step(s);
        check("spec_packet", bus.dout_leaf_interface2bft, SPEC_PKT);

        for (int i = 0; i < 8; i++) begin
            s = idle(); s.vld = '1; s.rdy = 1'b1;
            for (int p = 0; p < N; p++) s.din[p*PAYLOAD_BITS +: PAYLOAD_BITS] = $urandom();
            step(s);
        end

        for (int i = 0; i < 8; i++) begin
            s = idle(); s.vld = '1; s.rdy = (i >= 5);
            for (int p = 0; p < N; p++) s.din[p*PAYLOAD_BITS +: PAYLOAD_BITS] = $urandom();
            step(s);
        end

        s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.din = 64'h1111_2222_3333_4444;
        s.cw = 1'b1; s.cfp = 4'd0; s.cl = 5'd7; s.cd = 4'd9;
        step(s);
        s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.din = 64'h5555_6666_7777_8888;
        step(s);

        for (int i = 0; i < 140; i++) begin
            s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.din[31:0] = $urandom();
            step(s);
        end
        s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.cv = 1'b1; s.cp = 4'd5; s.ca = 8'd50;
        step(s);
        s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.cv = 1'b1; s.cp = 4'd0; s.ca = 8'd1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.din[31:0] = $urandom();
            step(s);
        end
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.vld = 2'b01; s.rdy = 1'b1; s.din[31:0] = $urandom();
            s.cv = 1'b1; s.cp = 4'd0; s.ca = 8'd1;
            step(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.cv = 1'b1; s.cp = 4'd1; s.ca = 8'd255;
            step(s);
        end

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.vld = N'($urandom());
            for (int p = 0; p < N; p++) s.din[p*PAYLOAD_BITS +: PAYLOAD_BITS] = $urandom();
            s.rdy = ($urandom_range(3) != 0);
            s.cv  = ($urandom_range(3) == 0);
            s.cp  = port_t'($urandom_range(3));
            s.ca  = credit_t'($urandom_range(7));
            s.cw  = ($urandom_range(7) == 0);
            s.cfp = port_t'($urandom_range(3));
            s.cl  = leaf_t'($urandom());
            s.cd  = port_t'($urandom());
            step(s);
        end

        s = idle(); s.vld = '1; s.rdy = 1'b0; s.din = {$urandom(), $urandom()};
        step(s);
        s.rst_n = 1'b0; s.rdy = 1'b1;
        step(s);
        s = idle(); s.rdy = 1'b1;
        repeat (5) step(s);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
